seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader.sv | 172 +++++++++++++++++
 tb/tb_seg7_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// Recovers hex digits from the segment lines of an external 7-segment driver.
// Each synchronized pattern must hold for STABLE_CYCLES samples before it is accepted.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic [6:0] abcdefg,
  output logic [3:0] number,
  output logic       valid,
  output logic       blank,
  output logic       new_digit,
  output logic       step_error,
  output logic       bad_pattern,
  output logic [7:0] digit_count,
  output logic       fsm_state
);

  typedef enum logic {
    EMPTY  = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] CNT_FULL = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] sync1;
  logic [6:0] sync2;
  logic [7:0] stab_cnt;
  logic [6:0] acc_pat;
  logic       acc_valid;

  state_t     state;
  state_t     state_n;
  logic [3:0] number_n;
  logic       valid_n;
  logic       blank_n;
  logic       new_digit_n;
  logic       step_error_n;
  logic       bad_pattern_n;
  logic [7:0] digit_count_n;

  logic       changing;
  logic       accept;
  logic       fresh;
  logic       is_digit;
  logic [3:0] dec_digit;
  logic       is_blank;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= abcdefg;
      sync2 <= sync1;
    end
  end

  // Looking one stage ahead lets the counter restart on the same edge sync2 changes,
  // which gives an input-to-pulse latency of STABLE_CYCLES+2.
  assign changing = (sync1 != sync2);
  assign accept   = !changing && (stab_cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      stab_cnt <= '0;
    end else if (changing) begin
      stab_cnt <= '0;
    end else if (stab_cnt != CNT_FULL) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // A pattern that returns after a short glitch matches the one already accepted
  // and must not produce a second acceptance.
  assign fresh = accept && !(acc_valid && (sync2 == acc_pat));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      acc_pat   <= '0;
      acc_valid <= 1'b0;
    end else if (accept) begin
      acc_pat   <= sync2;
      acc_valid <= 1'b1;
    end
  end

  always_comb begin
    is_digit  = 1'b1;
    dec_digit = 4'h0;
    case (sync2)
      7'b1111110: dec_digit = 4'h0;
      7'b0110000: dec_digit = 4'h1;
      7'b1101101: dec_digit = 4'h2;
      7'b1111001: dec_digit = 4'h3;
      7'b0110011: dec_digit = 4'h4;
      7'b1011011: dec_digit = 4'h5;
      7'b1011111: dec_digit = 4'h6;
      7'b1110000: dec_digit = 4'h7;
      7'b1111111: dec_digit = 4'h8;
      7'b1111011: dec_digit = 4'h9;
      7'b1110111: dec_digit = 4'hA;
      7'b0011111: dec_digit = 4'hB;
      7'b1001110: dec_digit = 4'hC;
      7'b0111101: dec_digit = 4'hD;
      7'b1001111: dec_digit = 4'hE;
      7'b1000111: dec_digit = 4'hF;
      default:    is_digit  = 1'b0;
    endcase
  end

  assign is_blank = (sync2 == 7'b0000000);

  always_comb begin
    state_n       = state;
    number_n      = number;
    valid_n       = valid;
    blank_n       = blank;
    new_digit_n   = 1'b0;
    step_error_n  = 1'b0;
    bad_pattern_n = 1'b0;
    digit_count_n = digit_count;
    if (fresh) begin
      if (is_digit) begin
        number_n      = dec_digit;
        valid_n       = 1'b1;
        blank_n       = 1'b0;
        new_digit_n   = 1'b1;
        digit_count_n = digit_count + 8'd1;
        if ((state == LOCKED) && (dec_digit != 4'(number + 4'd1))) begin
          step_error_n = 1'b1;
        end
        state_n = LOCKED;
      end else if (is_blank) begin
        valid_n = 1'b0;
        blank_n = 1'b1;
        state_n = EMPTY;
      end else begin
        valid_n       = 1'b0;
        blank_n       = 1'b0;
        bad_pattern_n = 1'b1;
        state_n       = EMPTY;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      number      <= '0;
      valid       <= 1'b0;
      blank       <= 1'b0;
      new_digit   <= 1'b0;
      step_error  <= 1'b0;
      bad_pattern <= 1'b0;
      digit_count <= '0;
    end else begin
      state       <= state_n;
      number      <= number_n;
      valid       <= valid_n;
      blank       <= blank_n;
      new_digit   <= new_digit_n;
      step_error  <= step_error_n;
      bad_pattern <= bad_pattern_n;
      digit_count <= digit_count_n;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: reset, latency, counting sequence, step errors,
// glitch rejection, bad/blank patterns and reset during acceptance.
module tb_seg7_reader;

  logic       CLK;
  logic       reset_n;
  logic [6:0] abcdefg;
  logic [3:0] number;
  logic       valid;
  logic       blank;
  logic       new_digit;
  logic       step_error;
  logic       bad_pattern;
  logic [7:0] digit_count;
  logic       fsm_state;

  int checks = 0;
  int passes = 0;
  int pulses;
  int errs;

  logic [6:0] seg [16];

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .abcdefg    (abcdefg),
    .number     (number),
    .valid      (valid),
    .blank      (blank),
    .new_digit  (new_digit),
    .step_error (step_error),
    .bad_pattern(bad_pattern),
    .digit_count(digit_count),
    .fsm_state  (fsm_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    seg[0]  = 7'b1111110; seg[1]  = 7'b0110000; seg[2]  = 7'b1101101; seg[3]  = 7'b1111001;
    seg[4]  = 7'b0110011; seg[5]  = 7'b1011011; seg[6]  = 7'b1011111; seg[7]  = 7'b1110000;
    seg[8]  = 7'b1111111; seg[9]  = 7'b1111011; seg[10] = 7'b1110111; seg[11] = 7'b0011111;
    seg[12] = 7'b1001110; seg[13] = 7'b0111101; seg[14] = 7'b1001111; seg[15] = 7'b1000111;

    // Reset with digit 0 already on the lines
    reset_n = 1'b0;
    abcdefg = seg[0];
    tick(3);
    chk("rst_number", 8'(number), 8'h0);
    chk("rst_valid", 8'(valid), 8'h0);
    chk("rst_blank", 8'(blank), 8'h0);
    chk("rst_new_digit", 8'(new_digit), 8'h0);
    chk("rst_count", digit_count, 8'h0);
    chk("rst_state", 8'(fsm_state), 8'h0);

    reset_n = 1'b1;
    tick(5);
    chk("lat_early", 8'(new_digit), 8'h0);
    tick(1);
    chk("lat_new_digit", 8'(new_digit), 8'h1);
    chk("lat_number", 8'(number), 8'h0);
    chk("lat_valid", 8'(valid), 8'h1);
    chk("lat_step_error", 8'(step_error), 8'h0);
    chk("lat_count", digit_count, 8'h1);
    chk("lat_state", 8'(fsm_state), 8'h1);
    tick(1);
    chk("lat_pulse_width", 8'(new_digit), 8'h0);

    // Count 1..F then wrap to 0
    pulses = 0;
    errs   = 0;
    for (int d = 1; d <= 16; d++) begin
      abcdefg = seg[d % 16];
      for (int c = 0; c < 20; c++) begin
        tick(1);
        pulses += int'(new_digit);
        errs   += int'(step_error);
      end
    end
    chk("seq_pulses", 8'(pulses), 8'd16);
    chk("seq_step_errors", 8'(errs), 8'd0);
    chk("seq_count", digit_count, 8'd17);
    chk("seq_number", 8'(number), 8'h0);

    // 3 followed by 5
    abcdefg = seg[3];
    tick(20);
    abcdefg = seg[5];
    tick(5);
    chk("skip_early", 8'(new_digit), 8'h0);
    tick(1);
    chk("skip_new_digit", 8'(new_digit), 8'h1);
    chk("skip_step_error", 8'(step_error), 8'h1);
    chk("skip_number", 8'(number), 8'h5);
    tick(14);

    // 8 held with a 2-cycle glitch to 1
    abcdefg = seg[8];
    tick(20);
    chk("glitch_pre_number", 8'(number), 8'h8);
    abcdefg = seg[1];
    tick(2);
    abcdefg = seg[8];
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      pulses += int'(new_digit);
    end
    chk("glitch_pulses", 8'(pulses), 8'd0);
    chk("glitch_number", 8'(number), 8'h8);
    chk("glitch_valid", 8'(valid), 8'h1);

    // Illegal pattern, then blank, then 7
    abcdefg = 7'b0000001;
    tick(6);
    chk("bad_pulse", 8'(bad_pattern), 8'h1);
    chk("bad_valid", 8'(valid), 8'h0);
    chk("bad_blank", 8'(blank), 8'h0);
    chk("bad_number", 8'(number), 8'h8);
    chk("bad_new_digit", 8'(new_digit), 8'h0);
    chk("bad_state", 8'(fsm_state), 8'h0);
    tick(1);
    chk("bad_pulse_width", 8'(bad_pattern), 8'h0);
    tick(13);
    abcdefg = 7'b0000000;
    tick(6);
    chk("blank_blank", 8'(blank), 8'h1);
    chk("blank_valid", 8'(valid), 8'h0);
    chk("blank_bad", 8'(bad_pattern), 8'h0);
    chk("blank_new_digit", 8'(new_digit), 8'h0);
    chk("blank_number", 8'(number), 8'h8);
    tick(14);
    abcdefg = seg[7];
    tick(6);
    chk("after_blank_new", 8'(new_digit), 8'h1);
    chk("after_blank_step", 8'(step_error), 8'h0);
    chk("after_blank_valid", 8'(valid), 8'h1);
    chk("after_blank_blank", 8'(blank), 8'h0);
    chk("after_blank_number", 8'(number), 8'h7);
    chk("after_blank_count", digit_count, 8'd21);
    tick(14);

    // Reset mid-acceptance of digit 2
    abcdefg = seg[2];
    tick(3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_number", 8'(number), 8'h0);
    chk("mid_rst_valid", 8'(valid), 8'h0);
    chk("mid_rst_count", digit_count, 8'h0);
    chk("mid_rst_state", 8'(fsm_state), 8'h0);
    tick(2);
    chk("mid_rst_new_digit", 8'(new_digit), 8'h0);
    reset_n = 1'b1;
    tick(5);
    chk("mid_rst_early", 8'(new_digit), 8'h0);
    tick(1);
    chk("mid_rst_new", 8'(new_digit), 8'h1);
    chk("mid_rst_digit", 8'(number), 8'h2);
    chk("mid_rst_step", 8'(step_error), 8'h0);
    chk("mid_rst_count1", digit_count, 8'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
